// File: rtl/ebr_pkg.sv
// Shared types and constants for the EBR read-side stream blocks.
package ebr_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Output FIFO depth; also the total credit shared by in-flight reads and stored words.
    localparam int FIFO_DEPTH = 4;

    // Supported EBR read latencies: 1 = NOREG, 2 = OUTREG.
    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 2;

    // Tag travelling alongside each issued read until its data returns.
    typedef struct packed {
        logic vld;
        logic last;
    } tag_t;

    function automatic bit rd_latency_legal(input int lat);
        return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
    endfunction

endpackage

// File: rtl/ebr_rd_fifo.sv
// Small synchronous first-word-fallthrough FIFO with occupancy count.
// The caller guarantees no write while full unless a read happens in the same cycle.
module ebr_rd_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 37,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_rd;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign rd_valid = (count != '0);
    assign do_rd    = rd_en && rd_valid;
    // Head word is visible without a read; forced to zero when empty so the port is deterministic.
    assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

    // Storage write; contents are only observed through a valid head.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    // Pointer and occupancy bookkeeping; simultaneous write and read leaves count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= ptr_inc(wr_ptr);
            if (do_rd) rd_ptr <= ptr_inc(rd_ptr);
            case ({wr_en, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ebr_burst_reader.sv
// Read-side burst engine for a pseudo-dual-port EBR: issues one read per cycle,
// tracks the fixed read latency with a tag pipeline, and streams words out with backpressure.
module ebr_burst_reader
    import ebr_pkg::*;
#(
    parameter int DATA_WIDTH = 36,
    parameter int ADDR_WIDTH = 9,
    parameter int LEN_WIDTH  = 9,
    parameter int RD_LATENCY = 2
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    input  logic                  CMD_VALID,
    output logic                  CMD_READY,
    input  logic [ADDR_WIDTH-1:0] CMD_ADDR,
    input  logic [LEN_WIDTH-1:0]  CMD_LEN,
    output logic [ADDR_WIDTH-1:0] ADR,
    output logic                  CER,
    output logic                  OCER,
    input  logic [DATA_WIDTH-1:0] DO,
    output logic                  DOUT_VALID,
    input  logic                  DOUT_READY,
    output logic [DATA_WIDTH-1:0] DOUT_DATA,
    output logic                  DOUT_LAST,
    output logic                  BUSY
);

    if (!rd_latency_legal(RD_LATENCY)) begin : g_bad_latency
        $error("ebr_burst_reader: RD_LATENCY must be 1 (NOREG) or 2 (OUTREG)");
    end

    localparam int IW  = $clog2(RD_LATENCY + 2);
    localparam int FCW = $clog2(FIFO_DEPTH + 1);

    state_t                state;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [LEN_WIDTH-1:0]  remaining;
    // Stage 0 is the registered issue (it drives CER); the tag leaves from stage RD_LATENCY,
    // which is exactly the cycle DO holds the word addressed by that issue.
    tag_t [RD_LATENCY:0]   vld_pipe;
    logic [IW-1:0]         inflight;
    logic [FCW-1:0]        fifo_count;
    logic                  issue;
    logic                  exit_vld;
    logic                  pop;
    logic                  credit_ok;
    logic [DATA_WIDTH:0]   fifo_rd_data;

    assign exit_vld = vld_pipe[RD_LATENCY].vld;
    assign pop      = DOUT_VALID && DOUT_READY;
    assign CER      = vld_pipe[0].vld;
    assign DOUT_LAST = fifo_rd_data[DATA_WIDTH];
    assign DOUT_DATA = fifo_rd_data[DATA_WIDTH-1:0];

    // Credit: every outstanding read plus every stored word must fit in the FIFO if the
    // consumer stalls from now on. A pop this cycle is certain, so it frees one slot already;
    // without that term a full-rate burst would stall once per pipeline refill.
    always_comb begin
        credit_ok = (int'(inflight) + int'(fifo_count) - int'(pop)) < FIFO_DEPTH;
        issue     = (state == ISSUE) && credit_ok;
    end

    // Control FSM with registered CMD_READY/BUSY and the address/remaining counters.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state     <= IDLE;
            CMD_READY <= 1'b0;
            BUSY      <= 1'b0;
            cur_addr  <= '0;
            remaining <= '0;
        end else begin
            case (state)
                IDLE: begin
                    CMD_READY <= 1'b1;
                    if (CMD_VALID && CMD_READY) begin
                        cur_addr  <= CMD_ADDR;
                        remaining <= CMD_LEN;
                        state     <= ISSUE;
                        CMD_READY <= 1'b0;
                        BUSY      <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (issue) begin
                        cur_addr  <= cur_addr + 1'b1;
                        remaining <= remaining - 1'b1;
                        if (remaining == '0) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop && DOUT_LAST) begin
                        state     <= IDLE;
                        CMD_READY <= 1'b1;
                        BUSY      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // EBR read port: address captured on issue, output register enabled outside reset.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            ADR  <= '0;
            OCER <= 1'b0;
        end else begin
            OCER <= 1'b1;
            if (issue) ADR <= cur_addr;
        end
    end

    // Tag shift register; reset drops every outstanding tag so late DO values are never stored.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[0].vld  <= issue;
            vld_pipe[0].last <= issue && (remaining == '0);
            for (int i = 1; i <= RD_LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];
        end
    end

    // Count of reads issued whose data has not yet been written into the FIFO.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) inflight <= '0;
        else       inflight <= inflight + IW'(issue) - IW'(exit_vld);
    end

    ebr_rd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_WIDTH + 1)
    ) u_fifo (
        .clk      (CLK),
        .rst_n    (RSTN),
        .wr_en    (exit_vld),
        .wr_data  ({vld_pipe[RD_LATENCY].last, DO}),
        .rd_en    (DOUT_READY),
        .rd_valid (DOUT_VALID),
        .rd_data  (fifo_rd_data),
        .count    (fifo_count)
    );

endmodule

// File: tb/tb_ebr_burst_reader.sv
// Directed bench for ebr_burst_reader: an OUTREG instance (dut0) and a NOREG instance (dut1)
// each behind a simple EBR model whose word at address a is a*3.
module tb_ebr_burst_reader;

    logic CLK  = 1'b0;
    logic RSTN = 1'b0;
    always #5 CLK = ~CLK;

    logic        cmd_valid0, cmd_ready0, cer0, ocer0, dout_valid0, dout_ready0, dout_last0, busy0;
    logic [8:0]  cmd_addr0, cmd_len0, adr0;
    logic [35:0] do0, dout_data0;
    logic        cmd_valid1, cmd_ready1, cer1, ocer1, dout_valid1, dout_ready1, dout_last1, busy1;
    logic [8:0]  cmd_addr1, cmd_len1, adr1;
    logic [35:0] do1, dout_data1;

    int tests = 0;
    int fails = 0;

    logic [35:0] ram_q0, do_reg0, ram_q1;
    logic [35:0] data_q0[$], data_q1[$];
    logic        last_q0[$], last_q1[$];
    logic [8:0]  adr_q0[$];
    logic [4:0]  pat = 5'b01001;   // ready pattern 1,0,0,1,0 read from bit 0 upward

    ebr_burst_reader #(.RD_LATENCY(2)) dut0 (
        .CLK(CLK), .RSTN(RSTN), .CMD_VALID(cmd_valid0), .CMD_READY(cmd_ready0),
        .CMD_ADDR(cmd_addr0), .CMD_LEN(cmd_len0), .ADR(adr0), .CER(cer0), .OCER(ocer0),
        .DO(do0), .DOUT_VALID(dout_valid0), .DOUT_READY(dout_ready0),
        .DOUT_DATA(dout_data0), .DOUT_LAST(dout_last0), .BUSY(busy0)
    );

    ebr_burst_reader #(.RD_LATENCY(1)) dut1 (
        .CLK(CLK), .RSTN(RSTN), .CMD_VALID(cmd_valid1), .CMD_READY(cmd_ready1),
        .CMD_ADDR(cmd_addr1), .CMD_LEN(cmd_len1), .ADR(adr1), .CER(cer1), .OCER(ocer1),
        .DO(do1), .DOUT_VALID(dout_valid1), .DOUT_READY(dout_ready1),
        .DOUT_DATA(dout_data1), .DOUT_LAST(dout_last1), .BUSY(busy1)
    );

    // EBR models: read register on CER, optional output register on OCER.
    always @(posedge CLK) begin
        if (cer0)  ram_q0  <= {27'd0, adr0} * 36'd3;
        if (ocer0) do_reg0 <= ram_q0;
        if (cer1)  ram_q1  <= {27'd0, adr1} * 36'd3;
    end
    assign do0 = do_reg0;
    assign do1 = ram_q1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    // Monitor, sampled mid-cycle: collects issued addresses and accepted beats, checks the
    // outstanding-word bound and that a stalled beat is held.
    initial begin
        int          outst0 = 0;
        logic        prev_stall = 1'b0;
        logic [36:0] prev_word = '0;
        forever begin
            @(negedge CLK);
            if (!RSTN) begin
                outst0     = 0;
                prev_stall = 1'b0;
            end else begin
                if (cer0) begin
                    adr_q0.push_back(adr0);
                    outst0++;
                    chk("outstanding_le_4", outst0 <= 4, 1);
                end
                if (prev_stall) begin
                    chk("stall_valid", dout_valid0, 1);
                    chk("stall_hold", {dout_last0, dout_data0}, prev_word);
                end
                if (dout_valid0 && dout_ready0) begin
                    data_q0.push_back(dout_data0);
                    last_q0.push_back(dout_last0);
                    outst0--;
                end
                prev_stall = dout_valid0 && !dout_ready0;
                prev_word  = {dout_last0, dout_data0};
                if (dout_valid1 && dout_ready1) begin
                    data_q1.push_back(dout_data1);
                    last_q1.push_back(dout_last1);
                end
            end
        end
    end

    task automatic clear_q;
        data_q0.delete(); last_q0.delete(); adr_q0.delete();
        data_q1.delete(); last_q1.delete();
    endtask

    // One command on dut0, optionally under the backpressure pattern and with a stray
    // CMD_VALID held for a few cycles after acceptance; waits for completion (bounded).
    task automatic burst0(input logic [8:0] a, input logic [8:0] len, input bit bp);
        clear_q();
        cmd_addr0  = a;
        cmd_len0   = len;
        cmd_valid0 = 1'b1;
        tick;
        if (!bp) cmd_valid0 = 1'b0;
        cmd_addr0 = 9'h000;
        cmd_len0  = 9'h000;
        for (int k = 0; k < 400 && (busy0 || data_q0.size() < int'(len) + 1); k++) begin
            if (k == 3) cmd_valid0 = 1'b0;
            dout_ready0 = bp ? pat[k % 5] : 1'b1;
            tick;
        end
        dout_ready0 = 1'b1;
        cmd_valid0  = 1'b0;
    endtask

    task automatic check_burst(input string tag, input int a, input int len);
        chk({tag, "_beats"}, data_q0.size(), len + 1);
        chk({tag, "_reads"}, adr_q0.size(), len + 1);
        for (int i = 0; i <= len; i++) begin
            if (i < data_q0.size()) begin
                chk({tag, "_data"}, data_q0[i], ((a + i) % 512) * 3);
                chk({tag, "_last"}, last_q0[i], i == len);
            end
            if (i < adr_q0.size()) chk({tag, "_adr"}, adr_q0[i], (a + i) % 512);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"}, cmd_ready0, 0);
        chk({tag, "_adr"}, adr0, 0);
        chk({tag, "_cer"}, cer0, 0);
        chk({tag, "_ocer"}, ocer0, 0);
        chk({tag, "_valid"}, dout_valid0, 0);
        chk({tag, "_data"}, dout_data0, 0);
        chk({tag, "_last"}, dout_last0, 0);
        chk({tag, "_busy"}, busy0, 0);
    endtask

    initial begin
        cmd_valid0 = 0; cmd_addr0 = 0; cmd_len0 = 0; dout_ready0 = 1;
        cmd_valid1 = 0; cmd_addr1 = 0; cmd_len1 = 0; dout_ready1 = 1;

        // Reset state
        repeat (3) tick;
        check_reset_outputs("rst");
        chk("rst_ocer1", ocer1, 0);
        RSTN = 1'b1;
        tick;
        chk("post_rst_cmd_ready", cmd_ready0, 1);
        chk("post_rst_ocer", ocer0, 1);
        chk("post_rst_busy", busy0, 0);

        // Basic burst on both builds; first valid at cycle 4 (OUTREG) and 3 (NOREG)
        clear_q();
        cmd_addr0 = 9'h010; cmd_len0 = 9'd3; cmd_valid0 = 1'b1;
        cmd_addr1 = 9'h010; cmd_len1 = 9'd3; cmd_valid1 = 1'b1;
        tick;
        cmd_valid0 = 1'b0; cmd_valid1 = 1'b0;
        chk("accept_busy", busy0, 1);
        chk("accept_cmd_ready", cmd_ready0, 0);
        for (int k = 1; k <= 8; k++) begin
            tick;
            chk("lat2_valid", dout_valid0, (k >= 4) && (k <= 7));
            chk("lat1_valid", dout_valid1, (k >= 3) && (k <= 6));
        end
        chk("basic_idle", busy0, 0);
        chk("basic_cmd_ready", cmd_ready0, 1);
        chk("lat1_idle", busy1, 0);
        check_burst("basic", 'h010, 3);
        chk("lat1_beats", data_q1.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < data_q1.size()) begin
                chk("lat1_data", data_q1[i], (16 + i) * 3);
                chk("lat1_last", last_q1[i], i == 3);
            end
        end

        // Backpressure with stray CMD_VALID while busy
        burst0(9'h040, 9'd15, 1'b1);
        check_burst("bp", 'h040, 15);

        // Address wrap
        burst0(9'h1FE, 9'd3, 1'b0);
        check_burst("wrap", 'h1FE, 3);

        // Single word: idle and ready the cycle after its handshake
        clear_q();
        cmd_addr0 = 9'h0AA; cmd_len0 = 9'd0; cmd_valid0 = 1'b1;
        tick;
        cmd_valid0 = 1'b0;
        for (int k = 0; k < 20 && !dout_valid0; k++) tick;
        chk("single_valid", dout_valid0, 1);
        chk("single_last", dout_last0, 1);
        tick;
        chk("single_busy", busy0, 0);
        chk("single_cmd_ready", cmd_ready0, 1);
        chk("single_valid_off", dout_valid0, 0);
        check_burst("single", 'h0AA, 0);

        // Reset after two of eight beats
        clear_q();
        cmd_addr0 = 9'h080; cmd_len0 = 9'd7; cmd_valid0 = 1'b1;
        tick;
        cmd_valid0 = 1'b0;
        for (int k = 0; k < 40 && data_q0.size() < 2; k++) tick;
        chk("pre_rst_beats", data_q0.size(), 2);
        #1 RSTN = 1'b0;
        #1 check_reset_outputs("async_rst");
        tick;
        tick;
        RSTN = 1'b1;
        tick;
        burst0(9'h100, 9'd1, 1'b0);
        repeat (10) tick;
        check_burst("post_rst", 'h100, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
